// File: rtl/dvi_out_pkg.sv
// rtl/dvi_out_pkg.sv - colour constants, colour-bar table and GBRG packing for dvi_pixel_out
package dvi_out_pkg;

    localparam int BAR_W    = 80;
    localparam int NUM_BARS = 8;
    localparam int COL_W    = 10;

    localparam logic [23:0] COLOR_WHITE   = 24'hFFFFFF;
    localparam logic [23:0] COLOR_YELLOW  = 24'hFFFF00;
    localparam logic [23:0] COLOR_CYAN    = 24'h00FFFF;
    localparam logic [23:0] COLOR_GREEN   = 24'h00FF00;
    localparam logic [23:0] COLOR_MAGENTA = 24'hFF00FF;
    localparam logic [23:0] COLOR_RED     = 24'hFF0000;
    localparam logic [23:0] COLOR_BLUE    = 24'h0000FF;
    localparam logic [23:0] COLOR_BLACK   = 24'h000000;

    // {r,g,b} of each vertical bar, left to right
    function automatic logic [23:0] bar_color(input logic [2:0] idx);
        logic [23:0] rgb;
        case (idx)
            3'd0:    rgb = COLOR_WHITE;
            3'd1:    rgb = COLOR_YELLOW;
            3'd2:    rgb = COLOR_CYAN;
            3'd3:    rgb = COLOR_GREEN;
            3'd4:    rgb = COLOR_MAGENTA;
            3'd5:    rgb = COLOR_RED;
            3'd6:    rgb = COLOR_BLUE;
            default: rgb = COLOR_BLACK;
        endcase
        return rgb;
    endfunction

    // Columns past the last bar stay on the last (black) bar
    function automatic logic [2:0] bar_index(input logic [COL_W-1:0] col);
        logic [2:0] idx;
        idx = 3'd0;
        for (int i = 1; i < NUM_BARS; i++) begin
            if (int'(col) >= i * BAR_W) begin
                idx = 3'(i);
            end
        end
        return idx;
    endfunction

    function automatic logic [23:0] pack_gbrg(input logic [23:0] rgb);
        return {rgb[11:8], rgb[7:0], rgb[23:16], rgb[15:12]};
    endfunction

endpackage

// File: rtl/sync_delay_line.sv
// rtl/sync_delay_line.sv - WIDTH x DEPTH shift register, cleared to CLR_VAL on synchronous reset
module sync_delay_line #(
    parameter int               WIDTH   = 5,
    parameter int               DEPTH   = 1,
    parameter logic [WIDTH-1:0] CLR_VAL = '0
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout
);

    logic [DEPTH-1:0][WIDTH-1:0] stage_q;
    logic [DEPTH-1:0][WIDTH-1:0] stage_d;

    always_comb begin
        stage_d    = stage_q;
        stage_d[0] = din;
        for (int i = 1; i < DEPTH; i++) begin
            stage_d[i] = stage_q[i-1];
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            for (int i = 0; i < DEPTH; i++) begin
                stage_q[i] <= CLR_VAL;
            end
        end else begin
            stage_q <= stage_d;
        end
    end

    assign dout = stage_q[DEPTH-1];

endmodule

// File: rtl/dvi_pixel_out.sv
// rtl/dvi_pixel_out.sv - DVI output stage: sync alignment, GBRG DDR split, underflow fill and stats
// Optional colour-bar generator enabled by defining DVI_TEST_PATTERN_EN.
module dvi_pixel_out
    import dvi_out_pkg::*;
#(
    parameter int          PIPE_LAT   = 1,
    parameter logic [23:0] FILL_COLOR = 24'h000000,
    parameter logic        SYNC_ACT   = 1'b0
) (
    input  logic        Clk,
    input  logic        Reset_n,
    input  logic        hsync_in,
    input  logic        vsync_in,
    input  logic        blank_in,
    input  logic        rd_fifo_in,
    input  logic        fifo_empty,
    input  logic [7:0]  pixel_r,
    input  logic [7:0]  pixel_g,
    input  logic [7:0]  pixel_b,
    input  logic        clr_err,
    input  logic        test_en,
    output logic        hsync_out,
    output logic        vsync_out,
    output logic        de_out,
    output logic [11:0] word_hi,
    output logic [11:0] word_lo,
    output logic        underflow_sticky,
    output logic [15:0] underflow_cnt,
    output logic [15:0] frame_cnt
);

    // Delay-line bit order: {hs, vs, blank, rd, empty}
    localparam logic [4:0] DLY_IDLE = {~SYNC_ACT, ~SYNC_ACT, 1'b1, 1'b0, 1'b0};

    logic [4:0]  dly_out;
    logic        dly_hs, dly_vs, dly_blank, dly_rd, dly_empty;

    logic        hs_q, hs_d, vs_q, vs_d, de_q, de_d;
    logic [23:0] gbrg_q, gbrg_d;
    logic        sticky_q, sticky_d;
    logic [15:0] uf_cnt_q, uf_cnt_d;
    logic [15:0] frame_q, frame_d;
    logic        vs_prev_q, vs_prev_d;
    logic        underflow;
    logic        vs_act;
    logic [23:0] src_rgb;

    sync_delay_line #(
        .WIDTH   (5),
        .DEPTH   (PIPE_LAT),
        .CLR_VAL (DLY_IDLE)
    ) u_sync_delay_line (
        .clk    (Clk),
        .resetn (Reset_n),
        .din    ({hsync_in, vsync_in, blank_in, rd_fifo_in, fifo_empty}),
        .dout   (dly_out)
    );

    assign {dly_hs, dly_vs, dly_blank, dly_rd, dly_empty} = dly_out;

`ifdef DVI_TEST_PATTERN_EN
    logic [COL_W-1:0] col_q, col_d;

    always_comb begin
        col_d = col_q;
        if (dly_blank) begin
            col_d = '0;
        end else if (col_q != '1) begin
            col_d = col_q + 1'b1;
        end
    end

    always_ff @(posedge Clk) begin
        if (!Reset_n) begin
            col_q <= '0;
        end else begin
            col_q <= col_d;
        end
    end
`else
    logic unused_test_en;
    assign unused_test_en = test_en;
`endif

    always_comb begin
        src_rgb = {pixel_r, pixel_g, pixel_b};
`ifdef DVI_TEST_PATTERN_EN
        if (test_en) begin
            src_rgb = bar_color(bar_index(col_q));
        end
`endif
        // Blank and underflow override both live video and the bar pattern
        if (dly_blank || (dly_rd && dly_empty)) begin
            src_rgb = FILL_COLOR;
        end
        hs_d   = dly_hs;
        vs_d   = dly_vs;
        de_d   = ~dly_blank;
        gbrg_d = pack_gbrg(src_rgb);
    end

    // A clear in the same cycle as an underflow still records that underflow
    always_comb begin
        underflow = rd_fifo_in & fifo_empty;
        sticky_d  = sticky_q | underflow;
        uf_cnt_d  = uf_cnt_q;
        if (clr_err) begin
            sticky_d = underflow;
            uf_cnt_d = {15'd0, underflow};
        end else if (underflow && uf_cnt_q != 16'hFFFF) begin
            uf_cnt_d = uf_cnt_q + 16'd1;
        end
    end

    always_comb begin
        vs_act    = (vsync_in == SYNC_ACT);
        vs_prev_d = vs_act;
        frame_d   = frame_q;
        if (vs_act && !vs_prev_q) begin
            frame_d = frame_q + 16'd1;
        end
    end

    always_ff @(posedge Clk) begin
        if (!Reset_n) begin
            hs_q      <= ~SYNC_ACT;
            vs_q      <= ~SYNC_ACT;
            de_q      <= 1'b0;
            gbrg_q    <= '0;
            sticky_q  <= 1'b0;
            uf_cnt_q  <= '0;
            frame_q   <= '0;
            vs_prev_q <= 1'b0;
        end else begin
            hs_q      <= hs_d;
            vs_q      <= vs_d;
            de_q      <= de_d;
            gbrg_q    <= gbrg_d;
            sticky_q  <= sticky_d;
            uf_cnt_q  <= uf_cnt_d;
            frame_q   <= frame_d;
            vs_prev_q <= vs_prev_d;
        end
    end

    assign hsync_out        = hs_q;
    assign vsync_out        = vs_q;
    assign de_out           = de_q;
    assign word_hi          = gbrg_q[23:12];
    assign word_lo          = gbrg_q[11:0];
    assign underflow_sticky = sticky_q;
    assign underflow_cnt    = uf_cnt_q;
    assign frame_cnt        = frame_q;

endmodule

// File: tb/tb_dvi_pixel_out.sv
// tb/tb_dvi_pixel_out.sv - directed self-checking bench for dvi_pixel_out (PIPE_LAT 1 and 3)
module tb_dvi_pixel_out;

    logic        Clk = 1'b0;
    logic        Reset_n;
    logic        hsync_in, vsync_in, blank_in, rd_fifo_in, fifo_empty;
    logic [7:0]  pixel_r, pixel_g, pixel_b;
    logic        clr_err, test_en;

    logic        hsync_out, vsync_out, de_out, underflow_sticky;
    logic [11:0] word_hi, word_lo;
    logic [15:0] underflow_cnt, frame_cnt;

    logic        hsync_out3, vsync_out3, de_out3, underflow_sticky3;
    logic [11:0] word_hi3, word_lo3;
    logic [15:0] underflow_cnt3, frame_cnt3;

    int n_vec  = 0;
    int n_miss = 0;

    always #5 Clk = ~Clk;

    dvi_pixel_out #(.PIPE_LAT(1)) u_dut (
        .Clk(Clk), .Reset_n(Reset_n),
        .hsync_in(hsync_in), .vsync_in(vsync_in), .blank_in(blank_in),
        .rd_fifo_in(rd_fifo_in), .fifo_empty(fifo_empty),
        .pixel_r(pixel_r), .pixel_g(pixel_g), .pixel_b(pixel_b),
        .clr_err(clr_err), .test_en(test_en),
        .hsync_out(hsync_out), .vsync_out(vsync_out), .de_out(de_out),
        .word_hi(word_hi), .word_lo(word_lo),
        .underflow_sticky(underflow_sticky), .underflow_cnt(underflow_cnt),
        .frame_cnt(frame_cnt)
    );

    dvi_pixel_out #(.PIPE_LAT(3)) u_dut3 (
        .Clk(Clk), .Reset_n(Reset_n),
        .hsync_in(hsync_in), .vsync_in(vsync_in), .blank_in(blank_in),
        .rd_fifo_in(rd_fifo_in), .fifo_empty(fifo_empty),
        .pixel_r(pixel_r), .pixel_g(pixel_g), .pixel_b(pixel_b),
        .clr_err(clr_err), .test_en(test_en),
        .hsync_out(hsync_out3), .vsync_out(vsync_out3), .de_out(de_out3),
        .word_hi(word_hi3), .word_lo(word_lo3),
        .underflow_sticky(underflow_sticky3), .underflow_cnt(underflow_cnt3),
        .frame_cnt(frame_cnt3)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_miss++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    initial begin
        Reset_n    = 1'b0;
        hsync_in   = 1'b1;
        vsync_in   = 1'b1;
        blank_in   = 1'b1;
        rd_fifo_in = 1'b0;
        fifo_empty = 1'b0;
        pixel_r    = 8'h00;
        pixel_g    = 8'h00;
        pixel_b    = 8'h00;
        clr_err    = 1'b0;
        test_en    = 1'b0;
        tick();
        tick();

        chk("rst_hsync", hsync_out, 1);
        chk("rst_vsync", vsync_out, 1);
        chk("rst_de", de_out, 0);
        chk("rst_word_hi", word_hi, 0);
        chk("rst_word_lo", word_lo, 0);
        chk("rst_sticky", underflow_sticky, 0);
        chk("rst_uf_cnt", underflow_cnt, 0);
        chk("rst_frame_cnt", frame_cnt, 0);

        Reset_n = 1'b1;
        tick();

        // Pixel 12/A5/3C requested, data arrives one cycle later
        blank_in   = 1'b0;
        rd_fifo_in = 1'b1;
        tick();
        rd_fifo_in = 1'b0;
        pixel_r    = 8'h12;
        pixel_g    = 8'hA5;
        pixel_b    = 8'h3C;
        tick();
        chk("pix_de", de_out, 1);
        chk("pix_word_hi", word_hi, 12'h53C);
        chk("pix_word_lo", word_lo, 12'h12A);

        // Three underflowing requests, then a normal one
        pixel_r = 8'hFF;
        pixel_g = 8'hFF;
        pixel_b = 8'hFF;
        for (int i = 0; i < 5; i++) begin
            rd_fifo_in = (i < 3);
            fifo_empty = (i < 3);
            tick();
            if (i >= 1 && i <= 3) begin
                chk($sformatf("uf_fill_hi_%0d", i), word_hi, 12'h000);
                chk($sformatf("uf_fill_lo_%0d", i), word_lo, 12'h000);
            end
            if (i == 4) begin
                chk("uf_resume_hi", word_hi, 12'hFFF);
            end
        end
        chk("uf_sticky", underflow_sticky, 1);
        chk("uf_cnt3", underflow_cnt, 3);

        // Saturation: 3 + 65532 = FFFF, then one more must hold
        rd_fifo_in = 1'b1;
        fifo_empty = 1'b1;
        for (int i = 0; i < 65532; i++) begin
            tick();
        end
        chk("uf_cnt_max", underflow_cnt, 16'hFFFF);
        tick();
        chk("uf_cnt_sat", underflow_cnt, 16'hFFFF);

        clr_err = 1'b1;
        tick();
        chk("clr_uf_cnt", underflow_cnt, 1);
        chk("clr_uf_sticky", underflow_sticky, 1);
        rd_fifo_in = 1'b0;
        fifo_empty = 1'b0;
        tick();
        chk("clr_cnt", underflow_cnt, 0);
        chk("clr_sticky", underflow_sticky, 0);
        clr_err = 1'b0;

        // Two active-low vsync pulses
        for (int i = 0; i < 2; i++) begin
            vsync_in = 1'b0;
            tick();
            vsync_in = 1'b1;
            tick();
        end
        chk("frame_cnt2", frame_cnt, 2);

        // hsync assertion latency: 2 cycles at PIPE_LAT=1, 4 at PIPE_LAT=3
        tick();
        tick();
        tick();
        hsync_in = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk($sformatf("hs_lat1_%0d", i), hsync_out, (i >= 1) ? 0 : 1);
            chk($sformatf("hs_lat3_%0d", i), hsync_out3, (i >= 3) ? 0 : 1);
        end
        hsync_in = 1'b1;

        // Mid-line reset
        rd_fifo_in = 1'b1;
        fifo_empty = 1'b1;
        tick();
        fifo_empty = 1'b0;
        pixel_r    = 8'h12;
        pixel_g    = 8'hA5;
        pixel_b    = 8'h3C;
        tick();
        tick();
        chk("pre_rst_de", de_out, 1);
        chk("pre_rst_cnt", underflow_cnt, 1);
        Reset_n = 1'b0;
        tick();
        chk("mid_rst_de", de_out, 0);
        chk("mid_rst_hsync", hsync_out, 1);
        chk("mid_rst_vsync", vsync_out, 1);
        chk("mid_rst_word_hi", word_hi, 0);
        chk("mid_rst_word_lo", word_lo, 0);
        chk("mid_rst_cnt", underflow_cnt, 0);
        chk("mid_rst_sticky", underflow_sticky, 0);
        chk("mid_rst_frame", frame_cnt, 0);
        Reset_n = 1'b1;
        tick();
        chk("post_rst_de0", de_out, 0);
        tick();
        chk("post_rst_de1", de_out, 1);
        chk("post_rst_hi", word_hi, 12'h53C);
        chk("post_rst_lo", word_lo, 12'h12A);

`ifdef DVI_TEST_PATTERN_EN
        // 640-pixel colour-bar line; output after tick i shows pixel i-1
        rd_fifo_in = 1'b0;
        blank_in   = 1'b1;
        test_en    = 1'b1;
        tick();
        tick();
        for (int i = 0; i <= 640; i++) begin
            blank_in = (i >= 640);
            tick();
            if (i == 1) begin
                chk("bar_px0_hi", word_hi, 12'hFFF);
                chk("bar_px0_lo", word_lo, 12'hFFF);
            end
            if (i == 81) begin
                chk("bar_px80_hi", word_hi, 12'hF00);
                chk("bar_px80_lo", word_lo, 12'hFFF);
            end
            if (i == 640) begin
                chk("bar_px639_hi", word_hi, 12'h000);
                chk("bar_px639_de", de_out, 1);
            end
        end
        test_en = 1'b0;
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
